// File: rtl/time_set_ctrl_pkg.sv
// Shared types, field encodings and BCD helpers for the time-setting controller.
package time_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2,
    SET_SEC  = 2'd3
  } state_t;

  localparam logic [1:0] FSEL_NONE = 2'd0;
  localparam logic [1:0] FSEL_HOUR = 2'd1;
  localparam logic [1:0] FSEL_MIN  = 2'd2;
  localparam logic [1:0] FSEL_SEC  = 2'd3;

  // Bit positions of each BCD digit inside the packed display word
  localparam int SEC_U_LSB  = 0;
  localparam int SEC_U_MSB  = 3;
  localparam int SEC_T_LSB  = 4;
  localparam int SEC_T_MSB  = 6;
  localparam int MIN_U_LSB  = 7;
  localparam int MIN_U_MSB  = 10;
  localparam int MIN_T_LSB  = 11;
  localparam int MIN_T_MSB  = 13;
  localparam int HOUR_U_LSB = 14;
  localparam int HOUR_U_MSB = 17;
  localparam int HOUR_T_LSB = 18;
  localparam int HOUR_T_MSB = 19;

  // Field limits, held as two-digit BCD {tens, units}
  localparam logic [7:0] HOUR_MAX = 8'h23;
  localparam logic [7:0] MIN_MAX  = 8'h59;
  localparam logic [7:0] SEC_MAX  = 8'h59;

  localparam logic [5:0] MASK_HOUR = 6'b110000;
  localparam logic [5:0] MASK_MIN  = 6'b001100;
  localparam logic [5:0] MASK_SEC  = 6'b000011;

  // Two-digit BCD increment; bit 8 flags the wrap from max back to 00
  function automatic logic [8:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
    if (v == max) return 9'h100;
    if (v[3:0] == 4'd9) return {1'b0, v[7:4] + 4'd1, 4'd0};
    return {1'b0, v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [1:0] field_sel_of(input state_t s);
    case (s)
      SET_HOUR: return FSEL_HOUR;
      SET_MIN:  return FSEL_MIN;
      SET_SEC:  return FSEL_SEC;
      default:  return FSEL_NONE;
    endcase
  endfunction

  function automatic logic [5:0] mask_of(input state_t s);
    case (s)
      SET_HOUR: return MASK_HOUR;
      SET_MIN:  return MASK_MIN;
      SET_SEC:  return MASK_SEC;
      default:  return 6'b000000;
    endcase
  endfunction

endpackage

// File: rtl/time_set_ctrl_if.sv
// Button inputs and display-side outputs of the time-setting controller.
interface time_set_ctrl_if;
  logic        btn_mode;
  logic        btn_sel;
  logic        btn_inc;
  logic [19:0] time_data;
  logic        set_mode;
  logic [1:0]  field_sel;
  logic [5:0]  blank_mask;

  modport master (
    output btn_mode, btn_sel, btn_inc,
    input  time_data, set_mode, field_sel, blank_mask
  );

  modport slave (
    input  btn_mode, btn_sel, btn_inc,
    output time_data, set_mode, field_sel, blank_mask
  );
endinterface

// File: rtl/time_set_ctrl_tick_prescaler.sv
// Free-running modulo-DIV counter; tick is high on the last count of each period.
module tick_prescaler #(
  parameter int DIV = 4
) (
  input  logic clk_sys,
  input  logic rstn,
  input  logic clr,
  output logic tick
);
  localparam int W = $clog2(DIV);
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt_q;

  assign tick = (cnt_q == LAST);

  // Count 0..DIV-1, held at zero by reset or clr
  always_ff @(posedge clk_sys) begin
    if (!rstn || clr) cnt_q <= '0;
    else if (tick)    cnt_q <= '0;
    else              cnt_q <= cnt_q + 1'b1;
  end
endmodule

// File: rtl/time_set_ctrl.sv
// 24-hour BCD clock with button-driven set mode and blinking edit field.
module time_set_ctrl
  import time_ctrl_pkg::*;
#(
  parameter int TICK_DIV  = 100_000_000,
  parameter int BLINK_DIV = 25_000_000
) (
  input  logic           clk_sys,
  input  logic           rstn,
  time_set_ctrl_if.slave bus
);
  state_t     state_q, state_d;
  logic [7:0] hour_q, min_q, sec_q;
  logic [7:0] hour_d, min_d, sec_d;
  logic       mode_q, sel_q, inc_q;
  logic       phase_q, phase_d;
  logic       set_mode_q;
  logic [1:0] field_sel_q;
  logic [5:0] blank_mask_q;
  logic       mode_e, sel_e, inc_e;
  logic       edit_e;
  logic       sec_tick, blink_tick, sec_clr, blink_clr;
  logic [8:0] h_inc, m_inc, s_inc;

  assign mode_e = bus.btn_mode & ~mode_q;
  assign sel_e  = bus.btn_sel  & ~sel_q;
  assign inc_e  = bus.btn_inc  & ~inc_q;

  // A sel/inc edge that actually acts on the edit (SET state, no mode edge)
  assign edit_e    = (state_q != RUN) & ~mode_e & (sel_e | inc_e);
  assign sec_clr   = (state_q != RUN);
  assign blink_clr = (state_q == RUN) | edit_e;

  assign h_inc = bcd_inc(hour_q, HOUR_MAX);
  assign m_inc = bcd_inc(min_q,  MIN_MAX);
  assign s_inc = bcd_inc(sec_q,  SEC_MAX);

  tick_prescaler #(.DIV(TICK_DIV)) u_sec_div (
    .clk_sys (clk_sys),
    .rstn    (rstn),
    .clr     (sec_clr),
    .tick    (sec_tick)
  );

  tick_prescaler #(.DIV(BLINK_DIV)) u_blink_div (
    .clk_sys (clk_sys),
    .rstn    (rstn),
    .clr     (blink_clr),
    .tick    (blink_tick)
  );

  // Next state and time: mode beats sel beats inc; a RUN tick loses to a mode edge
  always_comb begin
    state_d = state_q;
    hour_d  = hour_q;
    min_d   = min_q;
    sec_d   = sec_q;
    if (state_q == RUN) begin
      if (mode_e) begin
        state_d = SET_HOUR;
      end else if (sec_tick) begin
        sec_d = s_inc[7:0];
        if (s_inc[8]) begin
          min_d = m_inc[7:0];
          if (m_inc[8]) hour_d = h_inc[7:0];
        end
      end
    end else if (mode_e) begin
      state_d = RUN;
    end else if (sel_e) begin
      case (state_q)
        SET_HOUR: state_d = SET_MIN;
        SET_MIN:  state_d = SET_SEC;
        default:  state_d = SET_HOUR;
      endcase
    end else if (inc_e) begin
      case (state_q)
        SET_HOUR: hour_d = h_inc[7:0];
        SET_MIN:  min_d  = m_inc[7:0];
        default:  sec_d  = s_inc[7:0];
      endcase
    end
  end

  // Blink phase restarts visible on entry and on every edit
  always_comb begin
    phase_d = 1'b0;
    if (!blink_clr) phase_d = phase_q ^ blink_tick;
  end

  // State, time, button history and registered display outputs
  always_ff @(posedge clk_sys) begin
    if (!rstn) begin
      state_q      <= RUN;
      hour_q       <= '0;
      min_q        <= '0;
      sec_q        <= '0;
      mode_q       <= 1'b0;
      sel_q        <= 1'b0;
      inc_q        <= 1'b0;
      phase_q      <= 1'b0;
      set_mode_q   <= 1'b0;
      field_sel_q  <= FSEL_NONE;
      blank_mask_q <= '0;
    end else begin
      state_q      <= state_d;
      hour_q       <= hour_d;
      min_q        <= min_d;
      sec_q        <= sec_d;
      mode_q       <= bus.btn_mode;
      sel_q        <= bus.btn_sel;
      inc_q        <= bus.btn_inc;
      phase_q      <= phase_d;
      set_mode_q   <= (state_d != RUN);
      field_sel_q  <= field_sel_of(state_d);
      blank_mask_q <= phase_d ? mask_of(state_d) : 6'b000000;
    end
  end

  // Pack the three BCD fields into the display word
  always_comb begin
    bus.time_data = '0;
    bus.time_data[SEC_U_MSB:SEC_U_LSB]   = sec_q[3:0];
    bus.time_data[SEC_T_MSB:SEC_T_LSB]   = sec_q[6:4];
    bus.time_data[MIN_U_MSB:MIN_U_LSB]   = min_q[3:0];
    bus.time_data[MIN_T_MSB:MIN_T_LSB]   = min_q[6:4];
    bus.time_data[HOUR_U_MSB:HOUR_U_LSB] = hour_q[3:0];
    bus.time_data[HOUR_T_MSB:HOUR_T_LSB] = hour_q[5:4];
  end

  assign bus.set_mode   = set_mode_q;
  assign bus.field_sel  = field_sel_q;
  assign bus.blank_mask = blank_mask_q;
endmodule

// File: doc/time_set_ctrl.md
Name: time_set_ctrl

Overview:
- Timekeeping and time-setting controller that produces the packed BCD HH:MM:SS word consumed by the seven-segment display driver.
- Runs a 24-hour clock from an internal 1 Hz prescaler.
- Provides a button-driven set mode: select hour, minute or second, then increment the selected field.
- Drives a per-digit blank mask so the field being edited blinks on the display.

Parameters:
- TICK_DIV, 100_000_000, clk_sys cycles per 1-second tick (≥2).
- BLINK_DIV, 25_000_000, clk_sys cycles per blink phase toggle (≥2).

Ports:
- clk_sys  input  1  system clock
- rstn  input  1  synchronous active-low reset, sampled on posedge clk_sys
- btn_mode  input  1  debounced level; rising edge enters/leaves set mode
- btn_sel  input  1  debounced level; rising edge advances the selected field
- btn_inc  input  1  debounced level; rising edge increments the selected field
- time_data  output  20  packed BCD: [3:0] sec units, [6:4] sec tens, [10:7] min units, [13:11] min tens, [17:14] hour units, [19:18] hour tens
- set_mode  output  1  high while in any SET state
- field_sel  output  2  0=none (RUN), 1=hour, 2=min, 3=sec
- blank_mask  output  6  one bit per digit, same order as time_data fields (bit0=sec units … bit5=hour tens); 1 blanks that digit

Behaviour:
- Reset (rstn=0 at a clock edge): time_data=0 (00:00:00), state=RUN, set_mode=0, field_sel=0, blank_mask=0. Prescaler, blink counter and button history registers are cleared. Reset mid-edit discards the edit; the clock restarts from 00:00:00.
- Edge detection:
  - Each button has a history register.
  - edge = btn & ~btn_q, evaluated at the clock edge where btn is first sampled high.
  - The action takes effect at that same edge, so outputs are updated one cycle after btn rises.
  - A held button yields exactly one edge.
  - After reset the history is 0, so a button already high at reset release produces one edge.
- FSM states: RUN, SET_HOUR, SET_MIN, SET_SEC.
  - RUN + mode edge -> SET_HOUR.
  - Any SET state + mode edge -> RUN.
  - sel edge: SET_HOUR -> SET_MIN -> SET_SEC -> SET_HOUR. sel edge in RUN is ignored.
  - inc edge in a SET state increments the selected field. inc edge in RUN is ignored.
- Same-cycle priority: mode > sel > inc; lower-priority edges in that cycle are dropped. A tick coinciding with a mode edge out of RUN is dropped.
- RUN timekeeping:
  - The prescaler counts 0..TICK_DIV-1; tick fires when the count equals TICK_DIV-1, and the count wraps to 0.
  - On tick, seconds increment with BCD carry: units 9->0 carries to tens; tens 5->0 carries to minutes; minutes likewise carry to hours.
  - Hours: 23 -> 00. Full wrap: 23:59:59 -> 00:00:00 in one tick.
- SET mode:
  - The prescaler is held at 0 and time does not advance.
  - On return to RUN the first tick occurs exactly TICK_DIV cycles after the exit edge.
  - inc wraps the selected field without carrying into neighbours: hour 23->00, minute 59->00, second 59->00.
  - BCD digits are never outside their legal range (hour tens ≤2, min/sec tens ≤5, units ≤9).
- Blink:
  - The blink counter runs only in SET states and toggles a phase bit every BLINK_DIV cycles.
  - On entering SET, or on any sel/inc edge, the counter and phase are cleared to 0, so the digits are visible.
  - blank_mask = phase ? mask of the selected field's two bits : 0. In RUN, blank_mask=0.
- All outputs are registered. field_sel and set_mode are decoded from registered state.

Decomposition:
- Package time_ctrl_pkg:
  - state enum (RUN, SET_HOUR, SET_MIN, SET_SEC)
  - field_sel encodings
  - time_data bit-slice constants
  - field limits (HOUR_MAX=23, MIN_MAX=59, SEC_MAX=59)
  - blank_mask per-field constants (hour 6'b110000, min 6'b001100, sec 6'b000011)
- Sub-module tick_prescaler (parameter DIV; inputs clk_sys, rstn, clr; output tick). Instantiate it twice: once for the 1 Hz tick (DIV=TICK_DIV) and once for the blink phase (DIV=BLINK_DIV).

Test Plan (TICK_DIV=4, BLINK_DIV=3):
- Reset release, no buttons for 40 cycles -> 10 ticks; time_data decodes 00:00:10; first tick 4 cycles after reset release; blank_mask=0 throughout.
- Preload via set mode to 23:59:58, return to RUN, wait 8 cycles -> 23:59:59 then 00:00:00; every BCD digit stays legal.
- mode edge, then 3 inc edges -> set_mode=1, field_sel=1, hour advances by 3; no ticks while in SET; after a mode edge, the first tick comes 4 cycles later.
- In SET_MIN at 59, inc edge -> minute 00, hour unchanged; btn_inc held 20 cycles -> exactly one increment.
- mode, sel and inc rising in the same cycle while in RUN -> state SET_HOUR, time unchanged.
- In SET_SEC, idle -> blank_mask toggles 0 / 6'b000011 every 3 cycles; inc edge -> blank_mask=0 next cycle; assert rstn=0 mid-edit -> all outputs 0, state RUN.
